// File: rtl/ask_uart_pkg.sv
// rtl/ask_uart_pkg.sv - shared types and helpers for the ASK UART receive path
package ask_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_ARM   = 3'd0,
        ST_IDLE  = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_STOP  = 3'd4
    } rx_state_e;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ask_envelope_detect.sv
// rtl/ask_envelope_detect.sv - carrier envelope detector producing the UART line level
module ask_envelope_detect
    import ask_uart_pkg::*;
#(
    parameter int carrier_timeout = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ask_rx,
    output logic       line
);

    localparam int GW = cnt_width(carrier_timeout + 1);
    localparam logic [GW-1:0] GAP_MAX = GW'(carrier_timeout);

    logic [2:0]    sync_q;
    logic [GW-1:0] gap_q;
    logic [GW-1:0] gap_d;
    logic          edge_seen;

    // The N leg carries the same envelope in antiphase; only P is used.
    logic unused_n_leg;
    assign unused_n_leg = ask_rx[1];

    assign edge_seen = sync_q[1] ^ sync_q[2];

    always_comb begin
        gap_d = gap_q;
        if (edge_seen) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            gap_q  <= GAP_MAX;
        end else begin
            sync_q <= {sync_q[1:0], ask_rx[0]};
            gap_q  <= gap_d;
        end
    end

    assign line = (gap_q < GAP_MAX);

endmodule

// File: rtl/axis_ask_uart_rx.sv
// rtl/axis_ask_uart_rx.sv - ASK carrier 8N1 receiver with a one-byte AXI-Stream output buffer
module axis_ask_uart_rx
    import ask_uart_pkg::*;
#(
    parameter int clkdiv_rx       = 50,
    parameter int carrier_timeout = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] ask_rx,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    input  logic       o_tready,
    output logic       overrun,
    output logic       frame_err
);

    localparam int BW = cnt_width(clkdiv_rx);
    localparam logic [BW-1:0] BIT_LAST  = BW'(clkdiv_rx - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(clkdiv_rx / 2 - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(UART_DATA_BITS - 1);

    logic line;

    ask_envelope_detect #(
        .carrier_timeout(carrier_timeout)
    ) u_env (
        .clk   (clk),
        .rst_n (rst_n),
        .ask_rx(ask_rx),
        .line  (line)
    );

    rx_state_e           state_q, state_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]       arm_cnt_q, arm_cnt_d;
    logic [2:0]          idx_q, idx_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [7:0]          tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;
    logic                byte_done;
    logic                stop_bad;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        arm_cnt_d = arm_cnt_q;
        idx_d     = idx_q;
        shreg_d   = shreg_q;
        byte_done = 1'b0;
        stop_bad  = 1'b0;
        case (state_q)
            ST_ARM: begin
                if (!line) begin
                    arm_cnt_d = '0;
                end else if (arm_cnt_q == BIT_LAST) begin
                    arm_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    arm_cnt_d = arm_cnt_q + 1'b1;
                end
            end
            ST_IDLE: begin
                if (!line) begin
                    state_d   = ST_START;
                    bit_cnt_d = HALF_LAST;
                end
            end
            ST_START: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (!line) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = BIT_LAST;
                    idx_d     = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DATA: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else begin
                    shreg_d[idx_q] = line;
                    bit_cnt_d      = BIT_LAST;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end else if (line) begin
                    byte_done = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    // A broken frame forces a full re-arm before trusting the line again.
                    stop_bad  = 1'b1;
                    arm_cnt_d = '0;
                    state_d   = ST_ARM;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_comb begin
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        overrun_d   = 1'b0;
        frame_err_d = stop_bad;
        if (tvalid_q && o_tready) begin
            tvalid_d = 1'b0;
        end
        if (byte_done) begin
            if (!tvalid_q || o_tready) begin
                tdata_d  = shreg_q;
                tvalid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARM;
            bit_cnt_q   <= '0;
            arm_cnt_q   <= '0;
            idx_q       <= '0;
            shreg_q     <= '0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            arm_cnt_q   <= arm_cnt_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign o_tdata   = tdata_q;
    assign o_tvalid  = tvalid_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_axis_ask_uart_rx.sv
// tb/tb_axis_ask_uart_rx.sv - directed self-checking bench for axis_ask_uart_rx
module tb_axis_ask_uart_rx;
    import ask_uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ask_rx = 2'b00;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       o_tready = 1'b0;
    logic       overrun;
    logic       frame_err;

    int total = 0;
    int bad = 0;

    int cyc = 0;
    int valid_hi = 0;
    int rise_cyc = 0;
    int ovr_cnt = 0;
    int fe_cnt = 0;
    int fs_cyc = 0;
    logic prev_v = 1'b0;
    logic ph = 1'b0;
    logic [7:0] rx_q[$];

    axis_ask_uart_rx #(
        .clkdiv_rx(50),
        .carrier_timeout(8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ask_rx   (ask_rx),
        .o_tdata  (o_tdata),
        .o_tvalid (o_tvalid),
        .o_tready (o_tready),
        .overrun  (overrun),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_tvalid && o_tready) rx_q.push_back(o_tdata);
        if (o_tvalid) begin
            valid_hi <= valid_hi + 1;
            if (!prev_v) rise_cyc <= cyc;
        end
        prev_v <= o_tvalid;
        if (overrun) ovr_cnt <= ovr_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    task automatic drive(input int n, input logic on);
        repeat (n) begin
            @(negedge clk);
            ask_rx = on ? (ph ? 2'b10 : 2'b01) : 2'b00;
            ph = ~ph;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_on);
        fs_cyc = cyc;
        drive(50, 1'b0);
        for (int i = 0; i < 8; i++) drive(50, b[i]);
        drive(50, stop_on);
    endtask

    task automatic test_reset;
        repeat (5) @(negedge clk);
        total++; if (o_tdata !== 8'h00) begin bad++; $display("FAIL rst_tdata got=%h exp=00", o_tdata); end
        total++; if (o_tvalid !== 1'b0) begin bad++; $display("FAIL rst_tvalid got=%b exp=0", o_tvalid); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rst_overrun got=%b exp=0", overrun); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL rst_frame_err got=%b exp=0", frame_err); end
        rst_n = 1'b1;
        drive(2000, 1'b0);
        total++; if (valid_hi !== 0) begin bad++; $display("FAIL nocar_valid got=%0d exp=0", valid_hi); end
        total++; if (fe_cnt !== 0) begin bad++; $display("FAIL nocar_frame_err got=%0d exp=0", fe_cnt); end
        total++; if (ovr_cnt !== 0) begin bad++; $display("FAIL nocar_overrun got=%0d exp=0", ovr_cnt); end
        total++; if (dut.state_q !== ST_ARM) begin bad++; $display("FAIL nocar_state got=%0d exp=%0d", dut.state_q, ST_ARM); end
    endtask

    task automatic test_single_byte;
        int n0, v0, lat;
        o_tready = 1'b1;
        drive(100, 1'b1);
        n0 = rx_q.size();
        v0 = valid_hi;
        send_frame(8'h55, 1'b1);
        drive(20, 1'b1);
        lat = rise_cyc - fs_cyc;
        total++; if (rx_q.size() !== n0 + 1) begin bad++; $display("FAIL single_count got=%0d exp=%0d", rx_q.size(), n0 + 1); end
        total++; if (rx_q.size() > 0 && rx_q[rx_q.size()-1] !== 8'h55) begin bad++; $display("FAIL single_data got=%h exp=55", rx_q[rx_q.size()-1]); end
        total++; if (valid_hi - v0 !== 1) begin bad++; $display("FAIL single_valid_width got=%0d exp=1", valid_hi - v0); end
        total++; if (lat < 480 || lat > 495) begin bad++; $display("FAIL single_latency got=%0d exp=480..495", lat); end
    endtask

    task automatic test_back_to_back;
        int n0, o0;
        o_tready = 1'b0;
        n0 = rx_q.size();
        o0 = ovr_cnt;
        send_frame(8'hA5, 1'b1);
        send_frame(8'h3C, 1'b1);
        drive(20, 1'b1);
        total++; if (o_tdata !== 8'hA5) begin bad++; $display("FAIL bp_hold_data got=%h exp=a5", o_tdata); end
        total++; if (o_tvalid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b exp=1", o_tvalid); end
        total++; if (ovr_cnt - o0 !== 1) begin bad++; $display("FAIL bp_overrun got=%0d exp=1", ovr_cnt - o0); end
        @(posedge clk); #1 o_tready = 1'b1;
        @(posedge clk); #1 o_tready = 1'b0;
        drive(10, 1'b1);
        total++; if (rx_q.size() !== n0 + 1) begin bad++; $display("FAIL bp_xfer_count got=%0d exp=%0d", rx_q.size(), n0 + 1); end
        total++; if (rx_q.size() > 0 && rx_q[rx_q.size()-1] !== 8'hA5) begin bad++; $display("FAIL bp_xfer_data got=%h exp=a5", rx_q[rx_q.size()-1]); end
        total++; if (o_tvalid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0", o_tvalid); end
    endtask

    task automatic test_frame_error;
        int n0, f0;
        o_tready = 1'b1;
        n0 = rx_q.size();
        f0 = fe_cnt;
        send_frame(8'h3C, 1'b0);
        drive(30, 1'b1);
        total++; if (fe_cnt - f0 !== 1) begin bad++; $display("FAIL fe_pulse got=%0d exp=1", fe_cnt - f0); end
        total++; if (rx_q.size() !== n0) begin bad++; $display("FAIL fe_no_byte got=%0d exp=%0d", rx_q.size(), n0); end
        // This 0x81 arms inside its own bit 0; the silence lets the misaligned frame die.
        send_frame(8'h81, 1'b1);
        drive(100, 1'b0);
        total++; if (rx_q.size() !== n0) begin bad++; $display("FAIL fe_unarmed_ignored got=%0d exp=%0d", rx_q.size(), n0); end
        drive(60, 1'b1);
        send_frame(8'h81, 1'b1);
        drive(20, 1'b1);
        total++; if (rx_q.size() !== n0 + 1) begin bad++; $display("FAIL fe_rearm_count got=%0d exp=%0d", rx_q.size(), n0 + 1); end
        total++; if (rx_q.size() > 0 && rx_q[rx_q.size()-1] !== 8'h81) begin bad++; $display("FAIL fe_rearm_data got=%h exp=81", rx_q[rx_q.size()-1]); end
    endtask

    task automatic test_glitch;
        int n0, o0, f0;
        n0 = rx_q.size();
        o0 = ovr_cnt;
        f0 = fe_cnt;
        drive(20, 1'b0);
        drive(100, 1'b1);
        total++; if (o_tvalid !== 1'b0 || rx_q.size() !== n0) begin bad++; $display("FAIL glitch_output got=%b/%0d exp=0/%0d", o_tvalid, rx_q.size(), n0); end
        total++; if (ovr_cnt !== o0 || fe_cnt !== f0) begin bad++; $display("FAIL glitch_pulses got=%0d/%0d exp=%0d/%0d", ovr_cnt, fe_cnt, o0, f0); end
        total++; if (dut.state_q !== ST_IDLE) begin bad++; $display("FAIL glitch_state got=%0d exp=%0d", dut.state_q, ST_IDLE); end
        o_tready = 1'b0;
        send_frame(8'hF0, 1'b1);
        drive(20, 1'b1);
        total++; if (o_tvalid !== 1'b1) begin bad++; $display("FAIL glitch_after_valid got=%b exp=1", o_tvalid); end
        total++; if (o_tdata !== 8'hF0) begin bad++; $display("FAIL glitch_after_data got=%h exp=f0", o_tdata); end
    endtask

    task automatic test_reset_mid_frame;
        int n0;
        logic [7:0] b;
        b = 8'h12;
        n0 = rx_q.size();
        drive(50, 1'b0);
        for (int i = 0; i < 3; i++) drive(50, b[i]);
        drive(25, b[3]);
        @(posedge clk); #3 rst_n = 1'b0;
        #1;
        total++; if (o_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_tvalid got=%b exp=0", o_tvalid); end
        total++; if (o_tdata !== 8'h00) begin bad++; $display("FAIL midrst_tdata got=%h exp=00", o_tdata); end
        total++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL midrst_pulses got=%b%b exp=00", overrun, frame_err); end
        repeat (5) @(negedge clk);
        o_tready = 1'b1;
        rst_n = 1'b1;
        drive(300, 1'b0);
        total++; if (rx_q.size() !== n0 || o_tvalid !== 1'b0) begin bad++; $display("FAIL midrst_no_byte got=%0d/%b exp=%0d/0", rx_q.size(), o_tvalid, n0); end
        total++; if (dut.state_q !== ST_ARM) begin bad++; $display("FAIL midrst_state got=%0d exp=%0d", dut.state_q, ST_ARM); end
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_back_to_back;
        test_frame_error;
        test_glitch;
        test_reset_mid_frame;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_ask_uart_rx.md
# axis_ask_uart_rx

Receive-side counterpart of the ASK UART transmit path. The block recovers the UART line from a 2-bit antiphase on-off-keyed carrier by envelope detection, deframes 8N1 characters and presents each received byte on an AXI-Stream master port. It sits between the IF demodulator pins and the byte-stream fabric, mirroring the transmit wrapper that drives the MULP/MULN pins.

## Interface
- `clkdiv_rx`, 50: clk cycles per UART bit; minimum 8.
- `carrier_timeout`, 8: clk cycles without a carrier edge before the carrier is declared absent; must be less than `clkdiv_rx/2`.
- `clk` input 1: single clock domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `ask_rx` input 2: ASK input; `[0]` is the P leg and `[1]` is the N leg; asynchronous to `clk`.
- `o_tdata` output 8: received byte.
- `o_tvalid` output 1: byte valid.
- `o_tready` input 1: downstream accept.
- `overrun` output 1: one-cycle pulse when a completed byte is dropped.
- `frame_err` output 1: one-cycle pulse when the stop bit reads 0.

## Operation
- **Envelope**
  - `ask_rx[0]` passes through a 2-FF synchronizer, then a third register for edge detection.
  - Any edge reloads `gap_cnt` to 0; otherwise `gap_cnt` increments and saturates at `carrier_timeout`.
  - `line` = 1 (carrier present, mark or idle) while `gap_cnt < carrier_timeout`; otherwise `line` = 0 (space).
  - `ask_rx[1]` is ignored.
- **Deframer FSM** (states `ARM`, `IDLE`, `START`, `DATA`, `STOP`):
  - `ARM`: counts consecutive `line`=1 cycles. After `clkdiv_rx` consecutive ones it goes to `IDLE`. Any 0 restarts the count.
  - `IDLE`: `line`=0 moves to `START` and loads `bit_cnt` = `clkdiv_rx/2 - 1`.
  - `START`: when `bit_cnt` reaches 0, `line` is sampled. If it is still 0, go to `DATA` with `bit_cnt` = `clkdiv_rx-1` and `idx`=0. Otherwise (false start) return to `IDLE`.
  - `DATA`: at each `bit_cnt`=0, sample `line` into `shreg[idx]` (LSB first). After `idx`=7, go to `STOP`.
  - `STOP`: at `bit_cnt`=0, sample `line`.
    - Stop = 1: the byte is complete; go to `IDLE`.
    - Stop = 0: pulse `frame_err`, discard the byte, go to `ARM`.
- **Output buffer** (one byte):
  - Byte complete with `o_tvalid`=0: load `o_tdata` and set `o_tvalid` next cycle.
  - Byte complete with `o_tvalid`=1 and `o_tready`=0 on that cycle: drop the new byte, pulse `overrun`, hold the old byte.
  - Completion on the same cycle as a handshake: the new byte loads and `o_tvalid` stays 1.
- **Handshake**
  - A transfer occurs when `o_tvalid` and `o_tready` are both 1.
  - `o_tdata` and `o_tvalid` are stable while `o_tvalid`=1 and `o_tready`=0.
  - `o_tvalid` does not depend combinationally on `o_tready`.

## Timing
- **Reset values:** `o_tdata`=0x00, `o_tvalid`=0, `overrun`=0, `frame_err`=0, FSM=`ARM`, `gap_cnt`=`carrier_timeout` (line=0), synchronizer=0.
- **`rst_n` assertion mid-frame:** immediate abort. Any held byte is lost, and the receiver must re-arm (`clkdiv_rx` mark cycles) before accepting a new start.
- **Carrier loss:** `line` falls `carrier_timeout`+3 cycles after the last input edge.
- **Carrier return:** `line` rises 3 cycles after the first input edge.
- **Latency:** stop-bit mid-sample to `o_tvalid`=1 is 1 cycle. `overrun` and `frame_err` pulse on the cycle after the stop sample.
- **Back-to-back frames:** accepted. `IDLE` is re-entered at the stop-bit mid-point.
- **Glitch rejection:** a carrier gap that leaves `line`=0 for less than `clkdiv_rx/2` cycles is rejected as a false start and produces no pulse.
- **Counter widths:** `bit_cnt` and the `ARM` counter are `$clog2(clkdiv_rx)` bits; `gap_cnt` is `$clog2(carrier_timeout+1)` bits.

## Structure
- **Shared package `ask_uart_pkg`:** FSM state encoding, `UART_DATA_BITS`=8, and the counter-width helper.
- **Sub-module `ask_envelope_detect`:** synchronizer, edge detection and gap counter. Inputs are `clk`, `rst_n` and `ask_rx`; output is `line`.
- **Top level:** FSM, shift register and output buffer.

## Test plan
All scenarios use defaults (`clkdiv_rx`=50, `carrier_timeout`=8) and a stimulus where the carrier toggles `ask_rx` as 2'b01/2'b10 every clk. The bench drives a 0 bit as 50 cycles without carrier and a 1 bit as 50 cycles with carrier.
- **Reset, no carrier:** hold `rst_n`=0 for 5 cycles, release, keep `ask_rx`=2'b00 for 2000 cycles. Required: `o_tvalid`, `frame_err` and `overrun` stay 0 throughout, and the FSM stays in `ARM`.
- **Single byte:** 100 cycles of carrier, then frame 0x55 with `o_tready`=1. Required: `o_tdata`=0x55 and `o_tvalid` high for exactly 1 cycle, 1 cycle after the stop mid-sample.
- **Backpressure:** frames 0xA5 then 0x3C back-to-back with `o_tready`=0. Required: `o_tdata` holds 0xA5, one `overrun` pulse at the second stop sample. Raising `o_tready` afterwards transfers only 0xA5.
- **Framing error:** frame 0x3C with the stop bit sent without carrier, followed by 30 cycles of carrier, then frame 0x81. Required: one `frame_err` pulse and no `o_tvalid` for 0x3C; 0x81 is ignored (re-arm not complete); a 0x81 sent after 60 cycles of carrier is received.
- **Glitch:** a 20-cycle carrier gap while in `IDLE`. Required: false start rejected, no output or pulses; a subsequent 0xF0 frame is received correctly.
- **Reset mid-frame:** assert `rst_n` during bit 3 of 0x12. Required: all outputs return to reset values within 0 cycles of assertion (asynchronous); 0x12 is never output.
